ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/ldm_stm_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Sequences an ARM-style block transfer (LDM/STM) one register at a time.
// Registers are visited in ascending index order, one word per transfer,
// with the lowest register at the lowest address. An optional base
// writeback is issued after the last transfer.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       request pulse, sampled only while idle
//   is_load, s_bit, writeback   operation type, CPSR restore, W bit
//   mode                        {P,U}: 00=DA 01=IA 10=DB 11=IB
//   base_reg, base_addr         base register index and value
//   reg_list                    bit i set = transfer Ri
//   busy, done                  operation in flight / completion pulse
//   rf_read_*                   register-file read request (data next cycle)
//   rf_write_*                  register-file write strobe, index, data, restore flag
//   mem_req/we/addr/wdata       memory request, held until mem_ack
//   mem_rdata, mem_ack          memory response, same cycle as ack
module ldm_stm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        s_bit,
  input  logic        writeback,
  input  logic [1:0]  mode,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  output logic        busy,
  output logic        done,
  output logic        rf_read_en,
  output logic [3:0]  rf_read_reg,
  input  logic [31:0] rf_read_value,
  output logic        rf_write_en,
  output logic [3:0]  rf_write_reg,
  output logic [31:0] rf_write_value,
  output logic        rf_write_restore_from_SPSR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned AW = 32;
  localparam int unsigned NW = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RF_RD, S_RD_WAIT, S_MEM, S_RF_WR, S_WB, S_DONE
  } state_t;

  state_t          state;
  logic            op_load;
  logic            op_s;
  logic            op_wb;
  logic            op_pre;
  logic            op_up;
  logic [3:0]      op_base_reg;
  logic [AW-1:0]   op_base;
  logic            base_in_list;
  logic [15:0]     pending;
  logic [3:0]      cur_idx;
  logic [AW-1:0]   addr;
  logic [NW-1:0]   n_regs;

  logic [NW-1:0]   pop_c;
  logic [3:0]      pick_c;
  logic [15:0]     pick_mask_c;
  logic [AW-1:0]   setup_four_n_c;
  logic [AW-1:0]   four_n_c;
  logic [AW-1:0]   start_addr_c;
  logic [AW-1:0]   wb_value_c;
  logic            wb_needed_c;

  // Register count and lowest pending register index.
  always_comb begin
    pop_c  = '0;
    pick_c = '0;
    for (int i = 0; i < 16; i++) begin
      pop_c = pop_c + NW'(pending[i]);
    end
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) pick_c = 4'(i);
    end
  end

  assign pick_mask_c    = 16'(1) << pick_c;
  assign setup_four_n_c = AW'(pop_c) << 2;
  assign four_n_c       = AW'(n_regs) << 2;

  // Lowest transfer address for each addressing mode.
  always_comb begin
    case ({op_pre, op_up})
      2'b00:   start_addr_c = op_base - setup_four_n_c + AW'(4);
      2'b01:   start_addr_c = op_base;
      2'b10:   start_addr_c = op_base - setup_four_n_c;
      default: start_addr_c = op_base + AW'(4);
    endcase
  end

  assign wb_value_c  = op_up ? (op_base + four_n_c) : (op_base - four_n_c);
  // A loaded base register keeps the loaded value, so writeback is dropped.
  assign wb_needed_c = op_wb && !(op_load && base_in_list);

  // Sequencer FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                      <= S_IDLE;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      rf_read_en                 <= 1'b0;
      rf_read_reg                <= '0;
      rf_write_en                <= 1'b0;
      rf_write_reg               <= '0;
      rf_write_value             <= '0;
      rf_write_restore_from_SPSR <= 1'b0;
      mem_req                    <= 1'b0;
      mem_we                     <= 1'b0;
      mem_addr                   <= '0;
      mem_wdata                  <= '0;
      op_load                    <= 1'b0;
      op_s                       <= 1'b0;
      op_wb                      <= 1'b0;
      op_pre                     <= 1'b0;
      op_up                      <= 1'b0;
      op_base_reg                <= '0;
      op_base                    <= '0;
      base_in_list               <= 1'b0;
      pending                    <= '0;
      cur_idx                    <= '0;
      addr                       <= '0;
      n_regs                     <= '0;
    end else begin
      done                       <= 1'b0;
      rf_read_en                 <= 1'b0;
      rf_write_en                <= 1'b0;
      rf_write_restore_from_SPSR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_load      <= is_load;
            op_s         <= s_bit;
            op_wb        <= writeback;
            op_pre       <= mode[1];
            op_up        <= mode[0];
            op_base_reg  <= base_reg;
            op_base      <= base_addr;
            base_in_list <= reg_list[base_reg];
            pending      <= reg_list;
            busy         <= 1'b1;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          n_regs <= pop_c;
          addr   <= start_addr_c;
          if (pending == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_idx <= pick_c;
            pending <= pending & ~pick_mask_c;
            if (op_load) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= start_addr_c & ~AW'(3);
              state    <= S_MEM;
            end else begin
              rf_read_en  <= 1'b1;
              rf_read_reg <= pick_c;
              state       <= S_RF_RD;
            end
          end
        end
        S_RF_RD: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          // A stored base register always carries the original base value.
          mem_wdata <= (cur_idx == op_base_reg) ? op_base : rf_read_value;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= addr & ~AW'(3);
          state     <= S_MEM;
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            addr    <= addr + AW'(4);
            if (op_load) begin
              rf_write_en                <= 1'b1;
              rf_write_reg               <= cur_idx;
              rf_write_value             <= mem_rdata;
              rf_write_restore_from_SPSR <= op_s && (cur_idx == 4'd15);
              state                      <= S_RF_WR;
            end else if (pending != '0) begin
              cur_idx     <= pick_c;
              pending     <= pending & ~pick_mask_c;
              rf_read_en  <= 1'b1;
              rf_read_reg <= pick_c;
              state       <= S_RF_RD;
            end else if (wb_needed_c) begin
              rf_write_en    <= 1'b1;
              rf_write_reg   <= op_base_reg;
              rf_write_value <= wb_value_c;
              state          <= S_WB;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RF_WR: begin
          if (pending != '0) begin
            cur_idx  <= pick_c;
            pending  <= pending & ~pick_mask_c;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr & ~AW'(3);
            state    <= S_MEM;
          end else if (wb_needed_c) begin
            rf_write_en    <= 1'b1;
            rf_write_reg   <= op_base_reg;
            rf_write_value <= wb_value_c;
            state          <= S_WB;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_WB: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: a transaction-level model predicts the
// memory, register-read and register-write events of each operation;
// a monitor matches DUT events against those predictions every cycle.
`timescale 1ns/1ps
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        s_bit = 1'b0;
  logic        writeback = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  base_reg = 4'd0;
  logic [31:0] base_addr = 32'h0;
  logic [15:0] reg_list = 16'h0;
  logic        busy, done;
  logic        rf_read_en;
  logic [3:0]  rf_read_reg;
  logic [31:0] rf_read_value = 32'h0;
  logic        rf_write_en;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_value;
  logic        rf_write_restore_from_SPSR;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  ldm_stm_sequencer dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .start                      (start),
    .is_load                    (is_load),
    .s_bit                      (s_bit),
    .writeback                  (writeback),
    .mode                       (mode),
    .base_reg                   (base_reg),
    .base_addr                  (base_addr),
    .reg_list                   (reg_list),
    .busy                       (busy),
    .done                       (done),
    .rf_read_en                 (rf_read_en),
    .rf_read_reg                (rf_read_reg),
    .rf_read_value              (rf_read_value),
    .rf_write_en                (rf_write_en),
    .rf_write_reg               (rf_write_reg),
    .rf_write_value             (rf_write_value),
    .rf_write_restore_from_SPSR (rf_write_restore_from_SPSR),
    .mem_req                    (mem_req),
    .mem_we                     (mem_we),
    .mem_addr                   (mem_addr),
    .mem_wdata                  (mem_wdata),
    .mem_rdata                  (mem_rdata),
    .mem_ack                    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] val;
    logic        rsr;
  } wr_op_t;

  mem_op_t     exp_mem[$];
  wr_op_t      exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  wr_op_t      obs_wr[$];

  logic [31:0] regs[16];
  int          checks = 0;
  int          errors = 0;
  int          acks_seen = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  logic        mon_en = 1'b0;
  logic        rd_pend = 1'b0;
  logic [3:0]  rd_reg_q = 4'd0;
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void fail_evt(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s got=%h exp=none", name, got);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Predict every event of one block transfer from the architectural rules.
  task automatic build_model(input logic ld, input logic s, input logic w, input logic [1:0] md,
                             input logic [3:0] br, input logic [31:0] base, input logic [15:0] lst);
    int          n;
    int          k;
    logic [31:0] low;
    logic [31:0] a;
    mem_op_t     m;
    wr_op_t      r;
    exp_mem.delete(); exp_wr.delete(); exp_rd.delete();
    obs_addr.delete(); obs_wdata.delete(); obs_wr.delete();
    acks_seen = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE_0000 | 32'(i);
    regs[br] = base;
    n = $countones(lst);
    if (md[0]) low = base + (md[1] ? 32'd4 : 32'd0);
    else       low = base - 32'(4 * n) + (md[1] ? 32'd0 : 32'd4);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        a = (low + 32'(4 * k)) & ~32'd3;
        k++;
        m.addr  = a;
        m.we    = !ld;
        m.wdata = ld ? 32'h0 : regs[i];
        exp_mem.push_back(m);
        if (ld) begin
          r.rg  = 4'(i);
          r.val = mem_word(a);
          r.rsr = s && (i == 15);
          exp_wr.push_back(r);
        end else begin
          exp_rd.push_back(4'(i));
        end
      end
    end
    if (w && n > 0 && !(ld && lst[br])) begin
      r.rg  = br;
      r.val = md[0] ? base + 32'(4 * n) : base - 32'(4 * n);
      r.rsr = 1'b0;
      exp_wr.push_back(r);
    end
  endtask

  // Register file and memory responders.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      rd_pend  = 1'b0;
    end else begin
      rf_read_value = rd_pend ? regs[rd_reg_q] : 32'hDEAD_BEEF;
      rd_pend  = rf_read_en;
      rd_reg_q = rf_read_reg;
      mem_ack  = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        mem_ack   = stray_ack;
        mem_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  // Event monitor: compares DUT activity with the predicted queues.
  always @(negedge clk) begin
    mem_op_t m;
    wr_op_t  r;
    wr_op_t  o;
    if (mon_en) begin
      if (rf_read_en) begin
        if (exp_rd.size() == 0) fail_evt("rd_unexpected", 32'(rf_read_reg));
        else chk("rd_reg", 32'(rf_read_reg), 32'(exp_rd.pop_front()));
      end
      if (mem_req) chk("mem_align", 32'(mem_addr[1:0]), 32'd0);
      if (mem_req && prev_req) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", 32'(mem_we), 32'(prev_we));
        chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ack) begin
        acks_seen++;
        obs_addr.push_back(mem_addr);
        obs_wdata.push_back(mem_wdata);
        if (exp_mem.size() == 0) fail_evt("mem_unexpected", mem_addr);
        else begin
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", 32'(mem_we), 32'(m.we));
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (rf_write_en) begin
        o.rg  = rf_write_reg;
        o.val = rf_write_value;
        o.rsr = rf_write_restore_from_SPSR;
        obs_wr.push_back(o);
        if (exp_wr.size() == 0) fail_evt("wr_unexpected", 32'(rf_write_reg));
        else begin
          r = exp_wr.pop_front();
          chk("wr_reg", 32'(rf_write_reg), 32'(r.rg));
          chk("wr_value", rf_write_value, r.val);
          chk("wr_restore", 32'(rf_write_restore_from_SPSR), 32'(r.rsr));
        end
      end else begin
        chk("restore_idle", 32'(rf_write_restore_from_SPSR), 32'd0);
      end
    end
    prev_req   = mem_req;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic zero_checks(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, rf_read_en, rf_write_en, rf_write_restore_from_SPSR,
                             mem_req, mem_we, rf_read_reg, rf_write_reg}), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wr_value"}, rf_write_value, 32'd0);
  endtask

  // Runs one operation; entered and left one time unit after a rising edge.
  task automatic do_txn(input logic ld, input logic s, input logic w, input logic [1:0] md,
                        input logic [3:0] br, input logic [31:0] base, input logic [15:0] lst,
                        input int dly, input int stray_k, output int done_k);
    build_model(ld, s, w, md, br, base, lst);
    ack_delay = dly;
    is_load = ld; s_bit = s; writeback = w; mode = md;
    base_reg = br; base_addr = base; reg_list = lst; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    done_k = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      chk("busy_active", 32'(busy), 32'd1);
      if (done) begin
        done_k = k;
        break;
      end
      if (k == stray_k) begin
        start = 1'b1; is_load = !ld; base_addr = 32'h00BA_D000;
        reg_list = 16'hFFFF; mode = ~md;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_k < 0) fail_evt("done_timeout", 32'(busy));
    @(posedge clk); #1;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("mem_left", 32'(exp_mem.size()), 32'd0);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dk;
    bit hit;
    repeat (2) @(posedge clk);
    #1;
    zero_checks("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // STM IA, three registers, immediate ack.
    do_txn(1'b0, 1'b0, 1'b0, 2'b01, 4'd13, 32'h1000, 16'h0013, 0, 0, dk);
    chk("t1_n", 32'(obs_addr.size()), 32'd3);
    chk("t1_a0", obs_addr[0], 32'h1000);
    chk("t1_a1", obs_addr[1], 32'h1004);
    chk("t1_a2", obs_addr[2], 32'h1008);
    chk("t1_d2", obs_wdata[2], 32'hC0DE_0004);
    chk("t1_nowr", 32'(obs_wr.size()), 32'd0);

    // LDM DB with R15 and S bit, writeback.
    do_txn(1'b1, 1'b1, 1'b1, 2'b10, 4'd13, 32'h2000, 16'h8006, 1, 0, dk);
    chk("t2_a0", obs_addr[0], 32'h1FF4);
    chk("t2_a2", obs_addr[2], 32'h1FFC);
    chk("t2_nwr", 32'(obs_wr.size()), 32'd4);
    chk("t2_r1_val", obs_wr[0].val, 32'hA5A5_45AE);
    chk("t2_r1_rsr", 32'(obs_wr[0].rsr), 32'd0);
    chk("t2_r15_rsr", 32'(obs_wr[2].rsr), 32'd1);
    chk("t2_wb_reg", 32'(obs_wr[3].rg), 32'd13);
    chk("t2_wb_val", obs_wr[3].val, 32'h1FF4);
    chk("t2_wb_rsr", 32'(obs_wr[3].rsr), 32'd0);

    // LDM IA loading the base register: no writeback.
    do_txn(1'b1, 1'b0, 1'b1, 2'b01, 4'd2, 32'h3000, 16'h0004, 0, 0, dk);
    chk("t3_nwr", 32'(obs_wr.size()), 32'd1);
    chk("t3_reg", 32'(obs_wr[0].rg), 32'd2);
    chk("t3_val", obs_wr[0].val, 32'hA5A5_6A5A);

    // Empty list with W=1 and stray acks.
    stray_ack = 1'b1;
    do_txn(1'b1, 1'b0, 1'b1, 2'b01, 4'd5, 32'h4000, 16'h0000, 0, 0, dk);
    chk("t4_done_lat", 32'(dk), 32'd2);
    chk("t4_nomem", 32'(obs_addr.size()), 32'd0);
    chk("t4_nowr", 32'(obs_wr.size()), 32'd0);

    // STM IA, slow memory, stray acks, start while busy.
    do_txn(1'b0, 1'b0, 1'b1, 2'b01, 4'd13, 32'h6000, 16'h00A1, 3, 2, dk);
    stray_ack = 1'b0;
    chk("t5_n", 32'(obs_addr.size()), 32'd3);
    chk("t5_a2", obs_addr[2], 32'h6008);
    chk("t5_wb", obs_wr[0].val, 32'h600C);

    // STM DA storing the base register, writeback.
    do_txn(1'b0, 1'b0, 1'b1, 2'b00, 4'd3, 32'h4000, 16'h0009, 1, 0, dk);
    chk("t6_a0", obs_addr[0], 32'h3FFC);
    chk("t6_base_data", obs_wdata[1], 32'h4000);
    chk("t6_wb", obs_wr[0].val, 32'h3FF8);

    // STM IB and LDM DA with R15 but S clear.
    do_txn(1'b0, 1'b0, 1'b1, 2'b11, 4'd0, 32'h7000, 16'hC002, 0, 0, dk);
    do_txn(1'b1, 1'b0, 1'b0, 2'b00, 4'd9, 32'h8000, 16'h8101, 2, 0, dk);
    chk("t8_a0", obs_addr[0], 32'h7FF8);
    chk("t8_r15_rsr", 32'(obs_wr[2].rsr), 32'd0);

    // Reset during the second memory access of a four-register LDM.
    build_model(1'b1, 1'b0, 1'b1, 2'b01, 4'd1, 32'h5000, 16'h00F0);
    ack_delay = 2;
    is_load = 1'b1; s_bit = 1'b0; writeback = 1'b1; mode = 2'b01;
    base_reg = 4'd1; base_addr = 32'h5000; reg_list = 16'h00F0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (acks_seen == 1 && mem_req && !mem_ack) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) fail_evt("second_mem_timeout", 32'(acks_seen));
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    zero_checks("midrst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_no_wr", 32'(rf_write_en), 32'd0);
      chk("rst_no_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    exp_mem.delete(); exp_wr.delete(); exp_rd.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Clean operation after reset: LDM IB including the base register.
    do_txn(1'b1, 1'b1, 1'b1, 2'b11, 4'd4, 32'h9000, 16'h0030, 1, 0, dk);
    chk("t10_a0", obs_addr[0], 32'h9004);
    chk("t10_nwr", 32'(obs_wr.size()), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
